aes_subword_seq: RTL
====================

# aes_subword_seq

Iterative SubWord sequencer for the crypto-extension AES datapath. It accepts a multi-byte word and feeds one byte per cycle through a single shared composite-field S-box (`aes_sbox`, built from the GF(16) primitives). It collects the substituted bytes and returns the full word over a valid/ready handshake. It sits between the instruction-level AES unit (SubWord/SubBytes steps of `aes32*` / `aes64*` and key schedule) and the one S-box instance, trading latency for area.

## Interface
Parameters:
- `NUM_BYTES`, default 4: bytes per word; legal values 2, 4, 8, 16.

Ports:
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `in_valid_i`  in  1  request word valid.
- `in_ready_o`  out  1  sequencer can accept a word this cycle.
- `data_i`  in  8*NUM_BYTES  word to substitute; byte k = `data_i[8k+7:8k]`.
- `inv_i`  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the word.
- `flush_i`  in  1  synchronous abort of the word in flight.
- `out_valid_o`  out  1  result word valid.
- `out_ready_i`  in  1  consumer accepts result.
- `data_o`  out  8*NUM_BYTES  substituted word, same byte ordering as `data_i`.
- `sbox_in_o`  out  8  byte presented to the shared S-box.
- `sbox_inv_o`  out  1  direction presented to the shared S-box.
- `sbox_out_i`  in  8  combinational S-box result for `sbox_in_o`.

## Operation
- FSM states: IDLE, RUN, DONE. Internal state: source buffer `src_q`, result buffer `res_q`, direction `inv_q`, byte counter `cnt_q` (width `$clog2(NUM_BYTES)`).
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i`: `src_q`<=`data_i`, `inv_q`<=`inv_i`, `cnt_q`<=0, go to RUN.
- RUN:
  - `sbox_in_o` = `src_q` byte `cnt_q`; `sbox_inv_o`=`inv_q`.
  - Each cycle, `res_q` byte `cnt_q` <= `sbox_out_i` and `cnt_q` increments.
  - When `cnt_q`==NUM_BYTES-1, go to DONE; `cnt_q` wraps to 0.
- DONE:
  - `out_valid_o`=1 and `data_o`=`res_q`, both held stable until `out_ready_i`.
  - `in_ready_o` = `out_ready_i`. This is the only combinational input-to-output path.
  - On `out_ready_i` with `in_valid_i`: capture the new word and go to RUN (back-to-back).
  - On `out_ready_i` without `in_valid_i`: go to IDLE.
- Outside RUN, `sbox_in_o`=0x00 and `sbox_inv_o`=0, to suppress toggling.
- `in_valid_i` while `in_ready_o`=0 is ignored; the requester must hold its word.
- `flush_i` has priority over all handshakes. Next state is IDLE, `cnt_q`<=0, `out_valid_o` drops the next cycle, and no capture happens that cycle. `res_q` contents are don't-care.
- `rst_i` has priority over `flush_i` and has the same effect, plus `src_q`, `res_q` and `inv_q` are cleared to 0.

## Timing
- Reset values: state IDLE; `in_ready_o`=1, `out_valid_o`=0, `data_o`=0, `sbox_in_o`=0, `sbox_inv_o`=0.
- Accept at cycle T means RUN during T+1 … T+NUM_BYTES, and `out_valid_o`=1 from T+NUM_BYTES+1.
- Latency is NUM_BYTES+1 cycles.
- Throughput:
  - With `out_ready_i` held high and a continuous request stream: one word per NUM_BYTES+1 cycles.
  - Otherwise: one word per NUM_BYTES+2 cycles.
- The S-box path is fully combinational within one cycle. `sbox_out_i` is sampled on the same edge that advances `cnt_q`.
- `data_o` is a register output; it only changes on the RUN→DONE transition and at reset.

## Structure
- In the shared package `aes_pkg`:
  - state enum type `aes_seq_state_e` (IDLE, RUN, DONE);
  - byte-width constant `AES_BYTE_W`=8.
- No sub-module inside this block. The S-box (`aes_sbox`, composite-field, using `aes_Sum` and the other GF(16) cells) is instantiated beside it at the next level up, and in the bench.

## Test plan
- Forward word: `data_i`=0x53020100, `inv_i`=0 → `out_valid_o` exactly 5 cycles after accept, `data_o`=0xED777C63; `sbox_in_o` sequence 0x00, 0x01, 0x02, 0x53.
- Inverse word: `data_i`=0xED777C63, `inv_i`=1 → `data_o`=0x53020100; `sbox_inv_o`=1 through RUN only.
- Back-to-back: `out_ready_i` held 1, two words presented continuously → second accepted in the DONE cycle of the first; results 5 cycles apart.
- Backpressure: `out_ready_i`=0 for 10 cycles in DONE → `data_o` and `out_valid_o` held stable, `in_ready_o`=0, a new `in_valid_i` is not captured.
- Flush at RUN with `cnt_q`=2 → next cycle IDLE, `in_ready_o`=1, no `out_valid_o` pulse; a following word 0x00000000 yields 0x63636363.
- Reset asserted in DONE and in RUN → next cycle all outputs at reset values; `rst_i`+`in_valid_i` together → no capture.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: byte width and the SubWord sequencer state type.
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_seq_state_e;

endpackage

// File: rtl/aes_subword_seq.sv
// Iterative SubWord sequencer: streams one byte per cycle through an external shared
// S-box and returns the substituted word over a valid/ready handshake.
module aes_subword_seq
  import aes_pkg::*;
#(
  parameter int NUM_BYTES = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [AES_BYTE_W*NUM_BYTES-1:0] data_i,
  input  logic                            inv_i,
  input  logic                            flush_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [AES_BYTE_W*NUM_BYTES-1:0] data_o,
  output logic [AES_BYTE_W-1:0]           sbox_in_o,
  output logic                            sbox_inv_o,
  input  logic [AES_BYTE_W-1:0]           sbox_out_i
);

  localparam int W     = AES_BYTE_W * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BYTES - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // a requester holds valid and its word stable until then, and valid is never withdrawn
  // by the sequencer once raised until out_ready_i is seen.
  aes_seq_state_e         state_q, state_d;
  logic [W-1:0]           src_q, src_d;
  logic [W-1:0]           res_q, res_d;
  logic [W-1:0]           out_q, out_d;
  logic                   inv_q, inv_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_BYTE_W-1:0]  cur_byte;
  logic                   accept;

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (cnt_q == CNT_W'(k)) cur_byte = src_q[AES_BYTE_W*k +: AES_BYTE_W];
    end
  end

  assign in_ready_o  = (state_q == IDLE) || ((state_q == DONE) && out_ready_i);
  assign out_valid_o = (state_q == DONE);
  assign data_o      = out_q;
  assign sbox_in_o   = (state_q == RUN) ? cur_byte : '0;
  assign sbox_inv_o  = (state_q == RUN) && inv_q;
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    out_d   = out_q;
    inv_d   = inv_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_d   = data_i;
          inv_d   = inv_i;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < NUM_BYTES; k++) begin
          if (cnt_q == CNT_W'(k)) res_d[AES_BYTE_W*k +: AES_BYTE_W] = sbox_out_i;
        end
        cnt_d = cnt_q + CNT_W'(1);
        // The output register is loaded only here so data_o never shows a partial word.
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          out_d   = res_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          if (in_valid_i) begin
            src_d   = data_i;
            inv_d   = inv_i;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      src_d   = src_q;
      inv_d   = inv_q;
      out_d   = out_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
